// File: rtl/hello_sched_pkg.sv
// Shared encodings for the "Hello" matcher scheduler: FSM states, matcher
// states, ASCII constants and the index-width helper.
package hello_sched_pkg;

    typedef enum logic {IDLE, XFER} sched_state_t;

    typedef enum logic [2:0] {
        CHECK_H, CHECK_E, CHECK_L1, CHECK_L2, CHECK_O
    } match_state_t;

    localparam logic [7:0] ASCII_H = 8'h48;
    localparam logic [7:0] ASCII_E = 8'h65;
    localparam logic [7:0] ASCII_L = 8'h6C;
    localparam logic [7:0] ASCII_O = 8'h6F;

    // Width of a source index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hello_match_core.sv
// "Hello" byte-pattern matcher. Advances only on enabled bytes; a mismatching
// byte is re-examined as a possible 'H' so overlapping starts ("HHello") match.
// match is the same-cycle detect, hit is its registered one-cycle-late copy.
module hello_match_core
    import hello_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] data,
    output logic       match,
    output logic       hit
);

    match_state_t state, state_nx;

    // Next matcher state and same-cycle detect.
    always_comb begin
        state_nx = state;
        match    = 1'b0;
        if (clr) begin
            state_nx = CHECK_H;
        end else if (en) begin
            state_nx = (data == ASCII_H) ? CHECK_E : CHECK_H;
            case (state)
                CHECK_E:  if (data == ASCII_E) state_nx = CHECK_L1;
                CHECK_L1: if (data == ASCII_L) state_nx = CHECK_L2;
                CHECK_L2: if (data == ASCII_L) state_nx = CHECK_O;
                CHECK_O: begin
                    if (data == ASCII_O) begin
                        state_nx = CHECK_H;
                        match    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Matcher state and registered hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CHECK_H;
            hit   <= 1'b0;
        end else begin
            state <= state_nx;
            hit   <= match;
        end
    end

endmodule

// File: rtl/hello_match_sched.sv
// Round-robin scheduler sharing one "Hello" matcher among N_SRC byte sources.
// A source owns the matcher for a whole frame; one idle cycle separates frames.
// Optional macro HELLO_SCHED_TIMEOUT_EN aborts a frame whose owner stalls.
module hello_match_sched
    import hello_sched_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            src_valid,
    input  logic [8*N_SRC-1:0]          src_data,
    input  logic [N_SRC-1:0]            src_last,
    output logic [N_SRC-1:0]            src_ready,
    output logic [N_SRC-1:0]            grant,
    output logic                        busy,
    output logic                        hit_pulse,
    output logic [idx_w(N_SRC)-1:0]     hit_id,
    output logic [CNT_W*N_SRC-1:0]      hit_cnt,
    output logic [N_SRC-1:0]            led,
    output logic                        abort
);

    localparam int IW = idx_w(N_SRC);

    sched_state_t                 state, state_nx;
    logic [IW-1:0]                ptr, owner, pick, cand;
    logic                         found, start, accept, last_acc, tmo, match;
    logic [N_SRC-1:0][7:0]        data_v;
    logic [N_SRC-1:0][CNT_W-1:0]  cnt;

    assign data_v    = src_data;
    assign busy      = (state == XFER);
    assign src_ready = grant & {N_SRC{state == XFER}};
    assign accept    = (state == XFER) && src_valid[owner];
    assign last_acc  = accept && src_last[owner];
    assign start     = (state == IDLE) && found;
    assign hit_cnt   = cnt;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = 0; k < N_SRC; k++) begin
            cand = IW'((int'(ptr) + k) % N_SRC);
            if (!found && src_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef HELLO_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Fires on the TIMEOUT-th consecutive cycle the owner presents nothing.
    assign tmo = (state == XFER) && !src_valid[owner] && (idle_cnt == TW'(TIMEOUT - 1));

    // Consecutive stall counter plus the registered abort pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= tmo;
            if (state != XFER || src_valid[owner] || tmo) idle_cnt <= '0;
            else                                           idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign abort = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // FSM next state: grant on any request, release on last byte or abort.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = XFER;
            XFER:    if (last_acc || tmo) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, owner and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else if (start) begin
            grant        <= '0;
            grant[pick]  <= 1'b1;
            owner        <= pick;
        end else if (last_acc || tmo) begin
            grant <= '0;
            ptr   <= (owner == IW'(N_SRC - 1)) ? '0 : owner + 1'b1;
        end
    end

    // Per-source saturating hit counters, LEDs and last hit source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_id <= '0;
            cnt    <= '0;
            led    <= '0;
        end else if (match) begin
            hit_id     <= owner;
            led[owner] <= ~led[owner];
            if (cnt[owner] != '1) cnt[owner] <= cnt[owner] + 1'b1;
        end
    end

    hello_match_core u_core (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clr   (start || tmo),
        .data  (data_v[owner]),
        .match (match),
        .hit   (hit_pulse)
    );

endmodule
